// File: rtl/nvdla_cacc_grp_sched_pkg.sv
// Shared definitions for the CACC ping-pong register-group scheduler.
// Holds the status encoding seen by software on status_0/status_1.
package nvdla_cacc_grp_sched_pkg;

   localparam int GRP_NUM = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PENDING = 2'd2
   } grp_status_t;

endpackage : nvdla_cacc_grp_sched_pkg

// File: rtl/nvdla_cacc_grp_fsm.sv
// Per-group state machine: IDLE -> PENDING on trigger, PENDING -> RUNNING on
// launch, RUNNING -> IDLE on done. Qualification of the events lives in the top.
module nvdla_cacc_grp_fsm
   import nvdla_cacc_grp_sched_pkg::*;
(
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rstn,
   input  logic        trig,
   input  logic        launch,
   input  logic        done,
   output grp_status_t status
);

   grp_status_t state_q;
   grp_status_t state_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of process ordering.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: next state is defaulted to the current state first, so no path
   // through this block leaves state_d unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (trig)   state_d = ST_PENDING;
         ST_PENDING: if (launch) state_d = ST_RUNNING;
         ST_RUNNING: if (done)   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign status = state_q;

endmodule : nvdla_cacc_grp_fsm

// File: rtl/nvdla_cacc_grp_sched.sv
// Ping-pong scheduler for two CACC register groups: accepts op_en triggers,
// launches layers strictly in consumer order and reports completion/errors.
module nvdla_cacc_grp_sched
   import nvdla_cacc_grp_sched_pkg::*;
(
   input  logic       nvdla_core_clk,
   input  logic       nvdla_core_rstn,
   input  logic       producer,
   input  logic       op_en_wr,
   input  logic       dp2reg_done,
   output logic       consumer,
   output logic [1:0] status_0,
   output logic [1:0] status_1,
   output logic       reg2dp_op_en,
   output logic       layer_start,
   output logic [1:0] done_intr,
   output logic       sched_err
);

   grp_status_t              st0;
   grp_status_t              st1;
   grp_status_t              cons_st;
   grp_status_t              prod_st;
   logic [GRP_NUM-1:0]       accept;
   logic [GRP_NUM-1:0]       launch;
   logic [GRP_NUM-1:0]       done_grp;
   logic                     running_any;
   logic                     launch_any;
   logic                     done_valid;
   logic                     err_now;

   always_comb begin
      cons_st     = consumer ? st1 : st0;
      prod_st     = producer ? st1 : st0;
      running_any = (st0 == ST_RUNNING) || (st1 == ST_RUNNING);

      // A trigger only lands on an IDLE group; anything else is a software error.
      accept      = '0;
      accept[0]   = op_en_wr && (producer == 1'b0) && (st0 == ST_IDLE);
      accept[1]   = op_en_wr && (producer == 1'b1) && (st1 == ST_IDLE);

      // Only the consumer group may launch, which enforces strict ping-pong order.
      launch_any  = (cons_st == ST_PENDING) && !running_any;
      launch      = '0;
      launch[consumer] = launch_any;

      done_valid  = dp2reg_done && (cons_st == ST_RUNNING);
      done_grp    = '0;
      done_grp[consumer] = done_valid;

      err_now     = (op_en_wr && (prod_st != ST_IDLE)) || (dp2reg_done && !done_valid);
   end

   nvdla_cacc_grp_fsm u_grp0 (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .trig            (accept[0]),
      .launch          (launch[0]),
      .done            (done_grp[0]),
      .status          (st0)
   );

   nvdla_cacc_grp_fsm u_grp1 (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .trig            (accept[1]),
      .launch          (launch[1]),
      .done            (done_grp[1]),
      .status          (st1)
   );

   // reg2dp_op_en tracks the next-cycle RUNNING state of the next-cycle consumer.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         consumer     <= 1'b0;
         layer_start  <= 1'b0;
         done_intr    <= 2'b00;
         reg2dp_op_en <= 1'b0;
         sched_err    <= 1'b0;
      end else begin
         consumer     <= consumer ^ done_valid;
         layer_start  <= launch_any;
         done_intr    <= done_grp;
         reg2dp_op_en <= launch_any || ((cons_st == ST_RUNNING) && !done_valid);
         sched_err    <= sched_err | err_now;
      end
   end

   assign status_0 = st0;
   assign status_1 = st1;

endmodule : nvdla_cacc_grp_sched

// File: tb/tb_nvdla_cacc_grp_sched.sv
// Directed bench for the CACC group scheduler: reset, single layer, ping-pong,
// error cases, simultaneous done/trigger and reset mid-layer.
module tb_nvdla_cacc_grp_sched;

   logic       nvdla_core_clk = 1'b0;
   logic       nvdla_core_rstn = 1'b0;
   logic       producer = 1'b0;
   logic       op_en_wr = 1'b0;
   logic       dp2reg_done = 1'b0;
   logic       consumer;
   logic [1:0] status_0;
   logic [1:0] status_1;
   logic       reg2dp_op_en;
   logic       layer_start;
   logic [1:0] done_intr;
   logic       sched_err;

   int checks = 0;
   int failures = 0;

   nvdla_cacc_grp_sched dut (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .producer        (producer),
      .op_en_wr        (op_en_wr),
      .dp2reg_done     (dp2reg_done),
      .consumer        (consumer),
      .status_0        (status_0),
      .status_1        (status_1),
      .reg2dp_op_en    (reg2dp_op_en),
      .layer_start     (layer_start),
      .done_intr       (done_intr),
      .sched_err       (sched_err)
   );

   always #5 nvdla_core_clk = ~nvdla_core_clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge nvdla_core_clk);
      #1;
   endtask

   task automatic do_reset();
      nvdla_core_rstn = 1'b0;
      producer = 1'b0; op_en_wr = 1'b0; dp2reg_done = 1'b0;
      step(); step();
      nvdla_core_rstn = 1'b1;
   endtask

   task automatic trigger(input logic grp);
      producer = grp; op_en_wr = 1'b1;
      step();
      op_en_wr = 1'b0;
   endtask

   task automatic done_pulse();
      dp2reg_done = 1'b1;
      step();
      dp2reg_done = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({consumer, status_0, status_1, reg2dp_op_en, layer_start, done_intr, sched_err} !== 10'b0) begin
         failures++; $display("FAIL reset_state got=%b expected=0000000000",
            {consumer, status_0, status_1, reg2dp_op_en, layer_start, done_intr, sched_err});
      end
   endtask

   task automatic test_single_layer();
      do_reset();
      step();
      trigger(1'b0);
      checks++; if (status_0 !== 2'd2) begin failures++; $display("FAIL single_pending status_0 got=%0d expected=2", status_0); end
      checks++; if ({layer_start, reg2dp_op_en} !== 2'b00) begin failures++; $display("FAIL single_pending start/op_en got=%b expected=00", {layer_start, reg2dp_op_en}); end
      step();
      checks++; if (status_0 !== 2'd1) begin failures++; $display("FAIL single_run status_0 got=%0d expected=1", status_0); end
      checks++; if ({layer_start, reg2dp_op_en, consumer} !== 3'b110) begin failures++; $display("FAIL single_run start/op_en/cons got=%b expected=110", {layer_start, reg2dp_op_en, consumer}); end
      step();
      checks++; if ({layer_start, reg2dp_op_en} !== 2'b01) begin failures++; $display("FAIL single_hold start/op_en got=%b expected=01", {layer_start, reg2dp_op_en}); end
   endtask

   task automatic test_ping_pong();
      do_reset();
      trigger(1'b0); step();
      trigger(1'b1);
      checks++; if ({status_0, status_1} !== 4'b0110) begin failures++; $display("FAIL pp_queued status got=%b expected=0110", {status_0, status_1}); end
      done_pulse();
      checks++; if ({status_0, done_intr, consumer, reg2dp_op_en} !== 6'b000110) begin
         failures++; $display("FAIL pp_done0 st0/intr/cons/op_en got=%b expected=000110", {status_0, done_intr, consumer, reg2dp_op_en});
      end
      checks++; if ({status_1, layer_start} !== 3'b100) begin failures++; $display("FAIL pp_gap st1/start got=%b expected=100", {status_1, layer_start}); end
      step();
      checks++; if ({status_1, layer_start, reg2dp_op_en, done_intr} !== 6'b011100) begin
         failures++; $display("FAIL pp_launch1 st1/start/op_en/intr got=%b expected=011100", {status_1, layer_start, reg2dp_op_en, done_intr});
      end
      done_pulse();
      checks++; if ({status_1, done_intr, consumer, sched_err} !== 6'b001000) begin
         failures++; $display("FAIL pp_done1 st1/intr/cons/err got=%b expected=001000", {status_1, done_intr, consumer, sched_err});
      end
   endtask

   task automatic test_double_trigger();
      do_reset();
      trigger(1'b0);
      trigger(1'b0);
      checks++; if ({status_0, status_1, sched_err} !== 5'b01001) begin
         failures++; $display("FAIL dbl_trig st0/st1/err got=%b expected=01001", {status_0, status_1, sched_err});
      end
      trigger(1'b0);
      checks++; if ({status_0, layer_start, sched_err} !== 4'b0101) begin
         failures++; $display("FAIL trig_running st0/start/err got=%b expected=0101", {status_0, layer_start, sched_err});
      end
   endtask

   task automatic test_stray_done();
      do_reset();
      done_pulse();
      checks++; if ({consumer, done_intr, sched_err} !== 4'b0001) begin
         failures++; $display("FAIL stray_done cons/intr/err got=%b expected=0001", {consumer, done_intr, sched_err});
      end
      repeat (3) step();
      checks++; if ({sched_err, status_0, status_1} !== 5'b10000) begin
         failures++; $display("FAIL err_sticky err/st0/st1 got=%b expected=10000", {sched_err, status_0, status_1});
      end
   endtask

   task automatic test_strict_order();
      do_reset();
      trigger(1'b1);
      checks++; if (status_1 !== 2'd2) begin failures++; $display("FAIL order_pending status_1 got=%0d expected=2", status_1); end
      repeat (6) step();
      checks++; if ({status_1, reg2dp_op_en, layer_start, consumer, status_0} !== 7'b1000000) begin
         failures++; $display("FAIL order_hold st1/op_en/start/cons/st0 got=%b expected=1000000",
            {status_1, reg2dp_op_en, layer_start, consumer, status_0});
      end
   endtask

   task automatic test_done_trigger_same_group();
      do_reset();
      trigger(1'b0); step();
      producer = 1'b0; op_en_wr = 1'b1; dp2reg_done = 1'b1;
      step();
      op_en_wr = 1'b0; dp2reg_done = 1'b0;
      checks++; if ({status_0, done_intr, consumer, sched_err} !== 6'b000111) begin
         failures++; $display("FAIL done_trig_same st0/intr/cons/err got=%b expected=000111", {status_0, done_intr, consumer, sched_err});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      trigger(1'b0); step();
      producer = 1'b1; op_en_wr = 1'b1; dp2reg_done = 1'b1;
      step();
      op_en_wr = 1'b0; dp2reg_done = 1'b0;
      checks++; if ({status_0, status_1, done_intr, consumer, sched_err} !== 8'b00100110) begin
         failures++; $display("FAIL b2b_m1 st0/st1/intr/cons/err got=%b expected=00100110",
            {status_0, status_1, done_intr, consumer, sched_err});
      end
      step();
      checks++; if ({status_1, layer_start, reg2dp_op_en} !== 4'b0111) begin
         failures++; $display("FAIL b2b_m2 st1/start/op_en got=%b expected=0111", {status_1, layer_start, reg2dp_op_en});
      end
   endtask

   task automatic test_reset_mid_layer();
      do_reset();
      trigger(1'b0); step();
      checks++; if (status_0 !== 2'd1) begin failures++; $display("FAIL mid_pre status_0 got=%0d expected=1", status_0); end
      #2;
      nvdla_core_rstn = 1'b0;
      #1;
      checks++; if ({consumer, status_0, status_1, reg2dp_op_en, layer_start, done_intr, sched_err} !== 10'b0) begin
         failures++; $display("FAIL mid_async got=%b expected=0000000000",
            {consumer, status_0, status_1, reg2dp_op_en, layer_start, done_intr, sched_err});
      end
      step();
      nvdla_core_rstn = 1'b1;
      done_pulse();
      checks++; if ({done_intr, consumer, sched_err, status_0} !== 6'b000100) begin
         failures++; $display("FAIL mid_post intr/cons/err/st0 got=%b expected=000100", {done_intr, consumer, sched_err, status_0});
      end
   endtask

   initial begin
      test_reset();
      test_single_layer();
      test_ping_pong();
      test_double_trigger();
      test_stray_done();
      test_strict_order();
      test_done_trigger_same_group();
      test_back_to_back();
      test_reset_mid_layer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule : tb_nvdla_cacc_grp_sched
